if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/rv32i_pkg.sv | 11 +
 rtl/fetch_fifo.sv | 64 ++++++
 rtl/if_stage.sv | 81 ++++++++
 tb/tb_if_stage.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I constants and the fetch-queue entry layout.
package rv32i_pkg;
  localparam int          XLEN        = 32;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
  localparam int          FETCH_DEPTH = 2;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with a registered head, synchronous clear and occupancy count.
module fetch_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clr_i,
  input  logic                       push_i,
  input  logic [DATA_W-1:0]          data_i,
  input  logic                       pop_i,
  output logic [DATA_W-1:0]          data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (clr_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push_i) wptr_d = wrap_inc(wptr_q);
      if (pop_i)  rptr_d = wrap_inc(rptr_q);
      case ({push_i, pop_i})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage is data only; validity is carried entirely by the pointers and count.
  always_ff @(posedge clk_i) begin
    if (push_i && !clr_i) mem_q[wptr_q] <= data_i;
  end

  assign data_o  = mem_q[rptr_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: issues in-order memory requests, tracks in-flight addresses,
// drops responses made stale by a redirect, and buffers fetched words for decode.
module if_stage
  import rv32i_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic [XLEN-1:0] pc,
  output logic            PCWrite,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            Flush,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_instr
);
  localparam int CW = $clog2(DEPTH+1);

  logic [CW-1:0]   out_cnt, q_cnt, disc_q, disc_d;
  logic [CW:0]     inflight;
  logic [XLEN-1:0] head_addr;
  fetch_entry_t    push_ent, head_ent;
  logic            q_push, q_pop;

  // Every slot is reserved at request time, so a returning word always finds room.
  assign inflight  = {1'b0, q_cnt} + {1'b0, out_cnt};
  assign imem_req  = !Reset && !Flush && (inflight < (CW+1)'(DEPTH));
  assign PCWrite   = imem_req && imem_gnt;
  assign imem_addr = pc;

  fetch_fifo #(.DATA_W(XLEN), .DEPTH(DEPTH)) u_addr_fifo (
    .clk_i   (Clk),
    .rst_i   (Reset),
    .clr_i   (1'b0),
    .push_i  (PCWrite),
    .data_i  (pc),
    .pop_i   (imem_rvalid),
    .data_o  (head_addr),
    .count_o (out_cnt)
  );

  assign push_ent = '{pc: head_addr, instr: imem_rdata};
  assign q_push   = imem_rvalid && (disc_q == '0) && !Flush;
  assign q_pop    = id_valid && id_ready;

  fetch_fifo #(.DATA_W($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_instr_q (
    .clk_i   (Clk),
    .rst_i   (Reset),
    .clr_i   (Flush),
    .push_i  (q_push),
    .data_i  (push_ent),
    .pop_i   (q_pop),
    .data_o  (head_ent),
    .count_o (q_cnt)
  );

  // Stale responses are a subset of the in-flight ones, so a redirect marks all of
  // them stale, minus the one being dropped this very cycle.
  always_comb begin
    disc_d = disc_q;
    if (Flush)
      disc_d = out_cnt - CW'(imem_rvalid);
    else if (imem_rvalid && (disc_q != '0))
      disc_d = disc_q - 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (Reset) disc_q <= '0;
    else       disc_q <= disc_d;
  end

  assign id_valid = !Reset && (q_cnt != '0);
  assign id_pc    = id_valid ? head_ent.pc    : '0;
  assign id_instr = id_valid ? head_ent.instr : NOP_INSTR;
endmodule

// File: tb/tb_if_stage.sv
// Directed scoreboard bench for if_stage: a bench-side memory, PC register and
// expected-instruction queue predict every word handed to decode.
module tb_if_stage;
  logic        Clk = 1'b0;
  logic        Reset, PCWrite, imem_req, imem_gnt, imem_rvalid, Flush;
  logic        id_valid, id_ready;
  logic [31:0] pc, imem_addr, imem_rdata, id_pc, id_instr;

  if_stage #(.DEPTH(2)) dut (
    .Clk(Clk), .Reset(Reset), .pc(pc), .PCWrite(PCWrite), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .Flush(Flush), .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_instr(id_instr)
  );

  always #5 Clk = ~Clk;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0] pend_addr[$];
  bit          pend_stale[$];
  logic [63:0] exp_q[$];
  int          n_cmp = 0, n_err = 0, grants = 0;
  bit          g, auto_mem;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return 32'hC0DE_0000 | {16'h0, a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    logic [63:0] e;
    logic [31:0] a;
    bit          s;
    @(negedge Clk);
    g = imem_req && imem_gnt;
    chk("imem_addr", imem_addr, pc);
    chk("id_valid", id_valid, {63'h0, (!Reset && exp_q.size() != 0)});
    if (Reset || exp_q.size() == 0) begin
      chk("id_instr_nop", id_instr, NOP);
      chk("id_pc_zero", id_pc, 0);
    end
    if (id_ready && !Flush && !Reset && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("id_pc", id_pc, e[63:32]);
      chk("id_instr", id_instr, e[31:0]);
    end
    if (imem_rvalid && !Reset && pend_addr.size() != 0) begin
      a = pend_addr.pop_front();
      s = pend_stale.pop_front();
      if (!s && !Flush) exp_q.push_back({a, instr_of(a)});
    end
    if (Flush) begin
      exp_q.delete();
      foreach (pend_stale[i]) pend_stale[i] = 1'b1;
    end
    if (g) begin
      pend_addr.push_back(pc);
      pend_stale.push_back(1'b0);
      grants++;
    end
    if (Reset) begin
      exp_q.delete();
      pend_addr.delete();
      pend_stale.delete();
    end
  endtask

  task automatic advance();
    @(posedge Clk);
    #1;
    if (g) pc = pc + 32'd4;
    imem_rvalid = auto_mem && g && (pend_addr.size() != 0);
    imem_rdata  = (pend_addr.size() != 0) ? instr_of(pend_addr[0]) : 32'h0;
  endtask

  task automatic drain(input int lim);
    int n = 0;
    while ((pend_addr.size() != 0 || exp_q.size() != 0 || imem_rvalid) && n < lim) begin
      sample();
      advance();
      n++;
    end
    chk("drain_bound", {63'h0, (n < lim)}, 1);
  endtask

  task automatic respond();
    imem_rvalid = 1'b1;
    imem_rdata  = instr_of(pend_addr[0]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; pc = 32'h0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    Flush = 1'b0; id_ready = 1'b1; auto_mem = 1'b1;

    // Reset state
    sample();
    chk("rst_req", imem_req, 0);
    chk("rst_pcwrite", PCWrite, 0);
    advance();

    // Zero-wait memory, decode always ready
    Reset = 1'b0; imem_gnt = 1'b1; pc = 32'h0;
    sample(); chk("zw_pcwrite_c0", PCWrite, 1); advance();
    sample(); chk("zw_pcwrite_c1", PCWrite, 1); chk("zw_c1_valid", id_valid, 0); advance();
    sample(); chk("zw_c2_valid", id_valid, 1); chk("zw_c2_pc", id_pc, 32'h0); advance();
    sample(); chk("zw_c3_pc", id_pc, 32'h4); advance();
    imem_gnt = 1'b0;
    drain(20);

    // Decode stalled: reservation caps grants, head held stable
    pc = 32'h0; id_ready = 1'b0; imem_gnt = 1'b1; grants = 0;
    for (int i = 0; i < 5; i++) begin
      sample();
      if (i >= 2) begin
        chk("stall_valid", id_valid, 1);
        chk("stall_pc", id_pc, 32'h0);
      end
      if (i == 4) chk("stall_req_low", imem_req, 0);
      advance();
    end
    chk("stall_grants", grants, 2);
    imem_gnt = 1'b0; id_ready = 1'b1;
    drain(20);

    // Grant withheld
    pc = 32'h40;
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("nognt_req", imem_req, 1);
      chk("nognt_pcwrite", PCWrite, 0);
      chk("nognt_addr", imem_addr, 32'h40);
      advance();
    end
    imem_gnt = 1'b1;
    sample(); advance();
    imem_gnt = 1'b0;
    drain(20);

    // Redirect with two requests in flight
    auto_mem = 1'b0; pc = 32'h10; imem_gnt = 1'b1;
    sample(); advance();
    sample(); advance();
    imem_gnt = 1'b0; Flush = 1'b1;
    sample(); chk("flush_req", imem_req, 0); chk("flush_pcwrite", PCWrite, 0); advance();
    Flush = 1'b0; pc = 32'h100;
    sample(); chk("flush_discard2", dut.disc_q, 2); advance();
    respond(); sample(); advance();
    respond(); sample(); advance();
    sample(); chk("flush_discard0", dut.disc_q, 0); advance();
    imem_gnt = 1'b1; auto_mem = 1'b1;
    sample(); advance();
    imem_gnt = 1'b0;
    sample(); advance();
    sample(); chk("redirect_first_pc", id_pc, 32'h100); advance();
    drain(20);

    // Redirect coinciding with a response
    auto_mem = 1'b0; pc = 32'h20; imem_gnt = 1'b1;
    sample(); advance();
    imem_gnt = 1'b0; Flush = 1'b1; respond();
    sample(); chk("flushrv_req", imem_req, 0); advance();
    Flush = 1'b0; pc = 32'h30;
    sample(); chk("flushrv_discard", dut.disc_q, 0); advance();
    imem_gnt = 1'b1; auto_mem = 1'b1;
    sample(); advance();
    imem_gnt = 1'b0;
    drain(20);

    // Reset with the reservation exhausted (queue entry plus an outstanding request)
    pc = 32'h200; id_ready = 1'b0; imem_gnt = 1'b1;
    sample(); advance();
    sample(); advance();
    Reset = 1'b1; imem_rvalid = 1'b0; auto_mem = 1'b0; imem_gnt = 1'b0;
    sample();
    chk("rst2_req", imem_req, 0);
    chk("rst2_pcwrite", PCWrite, 0);
    advance();
    sample();
    chk("rst2_qcnt", dut.q_cnt, 0);
    chk("rst2_outcnt", dut.out_cnt, 0);
    chk("rst2_req_held", imem_req, 0);
    advance();
    Reset = 1'b0; id_ready = 1'b1;
    sample();
    chk("post_rst_req", imem_req, 1);
    advance();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
